// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory bootloader.
package prog_loader_pkg;

  // Loader FSM states, in frame order.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Each 18-bit instruction arrives as three bytes: B0 (2 bits), B1, B2.
  localparam int BYTES_PER_WORD = 3;
  localparam int WORD_W         = 18;

  // Assemble an instruction word from its three byte fields.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [1:0] top,
    input logic [7:0] mid,
    input logic [7:0] low
  );
    return {top, mid, low};
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream bootloader for the RAT MCU program memory. Accepts a framed
// image (SYNC, count, 3-byte words, XOR checksum), writes the words into
// memory sequentially while holding the CPU in reset, and otherwise passes
// the CPU fetch address straight through to the memory.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 18,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  output logic              CPU_HOLD,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR
);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   count_q;
  logic [DATA_W-1:0]   word_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          chk_q;
  logic                load_err_q;

  logic                rx_ready;
  logic                accept;
  logic                is_sync;
  logic                last_word;
  logic                mem_we;
  logic                cpu_hold;
  logic                load_done;

  // The loader only stalls the byte stream while it is busy writing a word
  // or signalling completion; everywhere else a byte is taken immediately.
  assign rx_ready  = !(state_q == ST_WRITE || state_q == ST_DONE);
  assign accept    = RX_VALID && rx_ready;
  assign is_sync   = (RX_DATA == SYNC_BYTE);
  assign last_word = (wr_addr_q == count_q);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs; the CPU is held in every state that is
  // part of a load, including the error state, and released in DONE.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_hold = 1'b0;
        if (accept && is_sync) state_d = ST_CNT_HI;
      end
      ST_CNT_HI: if (accept) state_d = ST_CNT_LO;
      ST_CNT_LO: if (accept) state_d = ST_B0;
      ST_B0:     if (accept) state_d = ST_B1;
      ST_B1:     if (accept) state_d = ST_B2;
      ST_B2:     if (accept) state_d = ST_WRITE;
      ST_WRITE: begin
        mem_we  = 1'b1;
        state_d = last_word ? ST_CHK : ST_B0;
      end
      ST_CHK: begin
        if (accept) state_d = (RX_DATA == chk_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_ERR: begin
        if (accept && is_sync) state_d = ST_CNT_HI;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame datapath: count capture, word assembly, running checksum, write
  // address advance and the latched error flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_addr_q  <= '0;
      count_q    <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      chk_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (accept && is_sync) begin
            wr_addr_q  <= '0;
            chk_q      <= '0;
            load_err_q <= 1'b0;
          end
        end
        ST_CNT_HI: begin
          if (accept) count_q[9:8] <= RX_DATA[1:0];
        end
        ST_CNT_LO: begin
          if (accept) count_q[7:0] <= RX_DATA;
        end
        ST_B0: begin
          if (accept) begin
            word_q[17:16] <= RX_DATA[1:0];
            chk_q         <= chk_q ^ RX_DATA;
          end
        end
        ST_B1: begin
          if (accept) begin
            word_q[15:8] <= RX_DATA;
            chk_q        <= chk_q ^ RX_DATA;
          end
        end
        ST_B2: begin
          if (accept) begin
            word_q[7:0] <= RX_DATA;
            chk_q       <= chk_q ^ RX_DATA;
            // Separate write-data register so MEM_WDATA stays stable while
            // the next word is being assembled.
            wdata_q     <= pack_word(word_q[17:16], word_q[15:8], RX_DATA);
          end
        end
        ST_WRITE: begin
          // The final word leaves the address in place, so a full-depth
          // image ends at the top address without wrapping.
          if (!last_word) wr_addr_q <= wr_addr_q + ADDR_W'(1);
        end
        ST_CHK: begin
          if (accept && (RX_DATA != chk_q)) load_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign RX_READY  = rx_ready;
  assign MEM_ADDR  = cpu_hold ? wr_addr_q : CPU_ADDR;
  assign MEM_WDATA = wdata_q;
  assign MEM_WE    = mem_we;
  assign CPU_HOLD  = cpu_hold;
  assign LOAD_DONE = load_done;
  assign LOAD_ERR  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: builds framed images from random word lists,
// streams them in, and compares captured memory writes and status outputs
// against the expected contents derived from the frame.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [9:0]  CPU_ADDR = 10'h000;
  logic [9:0]  MEM_ADDR;
  logic [17:0] MEM_WDATA;
  logic        MEM_WE;
  logic        CPU_HOLD;
  logic        LOAD_DONE;
  logic        LOAD_ERR;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  prog_loader dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .CPU_ADDR  (CPU_ADDR),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_WE    (MEM_WE),
    .CPU_HOLD  (CPU_HOLD),
    .LOAD_DONE (LOAD_DONE),
    .LOAD_ERR  (LOAD_ERR)
  );

  // Observation log, sampled on the falling edge.
  logic [9:0]  wr_addr_log[$];
  logic [17:0] wr_data_log[$];
  int done_cnt  = 0;
  int we_nohold = 0;
  int done_hold = 0;
  int rdy_bad   = 0;

  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      wr_addr_log.push_back(MEM_ADDR);
      wr_data_log.push_back(MEM_WDATA);
      if (CPU_HOLD !== 1'b1) we_nohold++;
      if (RX_READY !== 1'b0) rdy_bad++;
    end
    if (LOAD_DONE === 1'b1) begin
      done_cnt++;
      if (CPU_HOLD !== 1'b0) done_hold++;
      if (RX_READY !== 1'b0) rdy_bad++;
    end
  end

  // Reference model state: words to load, frame bytes, expected writes.
  logic [17:0] exp_w[$];
  logic [7:0]  fq[$];
  logic [9:0]  exp_a[$];
  logic [17:0] exp_d[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic gen_words(input int n);
    logic [31:0] r;
    exp_w.delete();
    for (int i = 0; i < n; i++) begin
      r = $urandom;
      exp_w.push_back(r[17:0]);
    end
  endtask

  // Turn exp_w into frame bytes (appended to fq) and expected writes.
  task automatic build_frame(input bit bad);
    logic [31:0] r;
    logic [9:0]  cnt;
    logic [7:0]  b0, b1, b2, chk;
    cnt = 10'(exp_w.size() - 1);
    r = $urandom;
    fq.push_back(8'hA5);
    fq.push_back({r[5:0], cnt[9:8]});
    fq.push_back(cnt[7:0]);
    chk = 8'h00;
    for (int i = 0; i < exp_w.size(); i++) begin
      r  = $urandom;
      b0 = {r[5:0], exp_w[i][17:16]};
      b1 = exp_w[i][15:8];
      b2 = exp_w[i][7:0];
      fq.push_back(b0);
      fq.push_back(b1);
      fq.push_back(b2);
      chk = chk ^ b0 ^ b1 ^ b2;
      exp_a.push_back(10'(i));
      exp_d.push_back(exp_w[i]);
    end
    if (bad) chk = chk ^ (8'h01 << $urandom_range(0, 7));
    fq.push_back(chk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    t = 0;
    @(negedge CLK);
    while (RX_READY !== 1'b1 && t < 20) begin
      t++;
      @(negedge CLK);
    end
    if (RX_READY !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: RX_READY=%b after %0d cycles, want 1", RX_READY, t);
    end
    @(posedge CLK);
    #1;
    RX_VALID = 1'b0;
    RX_DATA  = 8'($urandom);
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input int maxgap);
    for (int i = 0; i < fq.size(); i++)
      send_byte(fq[i], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    CPU_ADDR = 10'($urandom);
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (CPU_HOLD !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", CPU_HOLD); end
    checks++; if (MEM_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", MEM_WE); end
    checks++; if (LOAD_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", LOAD_DONE); end
    checks++; if (LOAD_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", LOAD_ERR); end
    checks++; if (MEM_WDATA !== 18'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", MEM_WDATA); end
    checks++; if (RX_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", RX_READY); end
    checks++; if (MEM_ADDR !== CPU_ADDR) begin errors++; $display("FAIL reset_addr: got %h want %h", MEM_ADDR, CPU_ADDR); end
  endtask

  task automatic test_one_word();
    int base, d0;
    base = wr_addr_log.size();
    d0 = done_cnt;
    fq = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34, 8'h25};
    send_frame(0);
    checks++; if (wr_addr_log.size() - base !== 1) begin errors++; $display("FAIL one_word_count: got %0d writes want 1", wr_addr_log.size() - base); end
    if (wr_addr_log.size() > base) begin
      checks++; if (wr_addr_log[base] !== 10'h000) begin errors++; $display("FAIL one_word_addr: got %h want 000", wr_addr_log[base]); end
      checks++; if (wr_data_log[base] !== 18'h31234) begin errors++; $display("FAIL one_word_data: got %h want 31234", wr_data_log[base]); end
    end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL one_word_done: got %0d pulses want 1", done_cnt - d0); end
    checks++; if (done_hold !== 0) begin errors++; $display("FAIL one_word_hold_at_done: got %0d want 0", done_hold); end
    checks++; if (LOAD_ERR !== 1'b0) begin errors++; $display("FAIL one_word_err: got %b want 0", LOAD_ERR); end
    checks++; if (CPU_HOLD !== 1'b0) begin errors++; $display("FAIL one_word_hold_after: got %b want 0", CPU_HOLD); end
  endtask

  task automatic test_chk_error();
    int base, d0;
    base = wr_addr_log.size();
    d0 = done_cnt;
    fq = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34, 8'h26};
    send_frame(0);
    checks++; if (LOAD_ERR !== 1'b1) begin errors++; $display("FAIL chk_err_flag: got %b want 1", LOAD_ERR); end
    checks++; if (CPU_HOLD !== 1'b1) begin errors++; $display("FAIL chk_err_hold: got %b want 1", CPU_HOLD); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL chk_err_done: got %0d pulses want 0", done_cnt - d0); end
    checks++; if (wr_addr_log.size() - base !== 1) begin errors++; $display("FAIL chk_err_writes: got %0d want 1", wr_addr_log.size() - base); end
    send_byte(8'h00, 0);
    send_byte(8'h3C, 1);
    checks++; if (LOAD_ERR !== 1'b1 || CPU_HOLD !== 1'b1) begin errors++; $display("FAIL chk_err_noise: got err=%b hold=%b want 1/1", LOAD_ERR, CPU_HOLD); end
    base = wr_addr_log.size();
    d0 = done_cnt;
    gen_words($urandom_range(1, 16));
    fq.delete(); exp_a.delete(); exp_d.delete();
    build_frame(1'b0);
    send_frame(0);
    checks++; if (LOAD_ERR !== 1'b0) begin errors++; $display("FAIL chk_recover_err: got %b want 0", LOAD_ERR); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL chk_recover_done: got %0d want 1", done_cnt - d0); end
    checks++; if (wr_addr_log.size() - base !== exp_a.size()) begin errors++; $display("FAIL chk_recover_count: got %0d want %0d", wr_addr_log.size() - base, exp_a.size()); end
    for (int i = 0; i < exp_a.size() && base + i < wr_addr_log.size(); i++) begin
      checks++;
      if (wr_addr_log[base+i] !== exp_a[i] || wr_data_log[base+i] !== exp_d[i]) begin
        errors++;
        $display("FAIL chk_recover_word%0d: got %h@%h want %h@%h", i, wr_data_log[base+i], wr_addr_log[base+i], exp_d[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_full_depth();
    int base, d0;
    base = wr_addr_log.size();
    d0 = done_cnt;
    exp_w.delete();
    for (int i = 0; i < 1024; i++) exp_w.push_back(18'(i));
    fq.delete(); exp_a.delete(); exp_d.delete();
    build_frame(1'b0);
    send_frame(0);
    checks++; if (wr_addr_log.size() - base !== 1024) begin errors++; $display("FAIL full_count: got %0d want 1024", wr_addr_log.size() - base); end
    for (int i = 0; i < 1024 && base + i < wr_addr_log.size(); i++) begin
      checks++;
      if (wr_addr_log[base+i] !== exp_a[i] || wr_data_log[base+i] !== exp_d[i]) begin
        errors++;
        $display("FAIL full_word%0d: got %h@%h want %h@%h", i, wr_data_log[base+i], wr_addr_log[base+i], exp_d[i], exp_a[i]);
      end
    end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done: got %0d want 1", done_cnt - d0); end
    checks++; if (LOAD_ERR !== 1'b0) begin errors++; $display("FAIL full_err: got %b want 0", LOAD_ERR); end
  endtask

  task automatic test_passthrough();
    logic [7:0] noise [3];
    int base;
    noise = '{8'h00, 8'hFF, 8'h5A};
    base = wr_addr_log.size();
    for (int i = 0; i < 3; i++) begin
      CPU_ADDR = (i == 0) ? 10'h155 : 10'($urandom);
      send_byte(noise[i], 0);
      checks++; if (MEM_ADDR !== CPU_ADDR) begin errors++; $display("FAIL pass_addr%0d: got %h want %h", i, MEM_ADDR, CPU_ADDR); end
      checks++; if (CPU_HOLD !== 1'b0 || MEM_WE !== 1'b0) begin errors++; $display("FAIL pass_ctrl%0d: got hold=%b we=%b want 0/0", i, CPU_HOLD, MEM_WE); end
      checks++; if (RX_READY !== 1'b1) begin errors++; $display("FAIL pass_ready%0d: got %b want 1", i, RX_READY); end
    end
    checks++; if (wr_addr_log.size() !== base) begin errors++; $display("FAIL pass_writes: got %0d want %0d", wr_addr_log.size(), base); end
  endtask

  task automatic test_back_to_back();
    int base, d0;
    logic [7:0] tmp[$];
    base = wr_addr_log.size();
    d0 = done_cnt;
    fq.delete(); exp_a.delete(); exp_d.delete();
    gen_words($urandom_range(1, 12));
    build_frame(1'b0);
    gen_words($urandom_range(1, 12));
    build_frame(1'b0);
    send_frame(0);
    tmp = fq;
    fq.delete();
    gen_words($urandom_range(2, 10));
    build_frame(1'b0);
    send_frame(3);
    checks++; if (wr_addr_log.size() - base !== exp_a.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", wr_addr_log.size() - base, exp_a.size()); end
    for (int i = 0; i < exp_a.size() && base + i < wr_addr_log.size(); i++) begin
      checks++;
      if (wr_addr_log[base+i] !== exp_a[i] || wr_data_log[base+i] !== exp_d[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h@%h want %h@%h", i, wr_data_log[base+i], wr_addr_log[base+i], exp_d[i], exp_a[i]);
      end
    end
    checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL b2b_done: got %0d want 3 (frame bytes %0d)", done_cnt - d0, tmp.size()); end
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_ready_low: got %0d busy cycles with ready high want 0", rdy_bad); end
    checks++; if (we_nohold !== 0) begin errors++; $display("FAIL b2b_we_hold: got %0d writes without hold want 0", we_nohold); end
  endtask

  task automatic test_reset_midload();
    int base;
    base = wr_addr_log.size();
    fq.delete(); exp_a.delete(); exp_d.delete();
    gen_words(3);
    build_frame(1'b0);
    for (int i = 0; i < 8; i++) send_byte(fq[i], 0);
    CPU_ADDR = 10'($urandom);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (CPU_HOLD !== 1'b0) begin errors++; $display("FAIL rst_mid_hold: got %b want 0", CPU_HOLD); end
    checks++; if (MEM_WE !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b want 0", MEM_WE); end
    checks++; if (RX_READY !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", RX_READY); end
    checks++; if (MEM_ADDR !== CPU_ADDR) begin errors++; $display("FAIL rst_mid_addr: got %h want %h", MEM_ADDR, CPU_ADDR); end
    RST_N = 1'b1;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    checks++; if (wr_addr_log.size() - base !== 1) begin errors++; $display("FAIL rst_mid_writes: got %0d want 1", wr_addr_log.size() - base); end
    if (wr_addr_log.size() > base) begin
      checks++;
      if (wr_addr_log[base] !== 10'h000 || wr_data_log[base] !== exp_w[0]) begin
        errors++;
        $display("FAIL rst_mid_word1: got %h@%h want %h@000", wr_data_log[base], wr_addr_log[base], exp_w[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_chk_error();
    test_passthrough();
    test_back_to_back();
    test_full_depth();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
